// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit.
// Provides: XLEN, control-transfer opcodes, branch funct3 codes, FSM state
// encoding and a saturating counter increment helper.
package branch_resolve_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BREACH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REDIRECT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Bus between the EX stage / IFU and the branch resolution unit.
// master: pipeline side, drives the EX-stage instruction and redirect_ready.
// slave : branch_resolve, drives redirect request, flush/stall and counters.
interface branch_resolve_if;
  import branch_resolve_pkg::*;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [31:0]     ex_imm;
  logic [XLEN-1:0] ex_pred_pc;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  logic            flush;
  logic            stall_ex;
  logic [31:0]     branch_cnt;
  logic [31:0]     mispred_cnt;

  modport master (
    output ex_valid, ex_pc, ex_opcode, ex_funct3, ex_rs1_val, ex_rs2_val,
           ex_imm, ex_pred_pc, redirect_ready,
    input  redirect_valid, redirect_pc, flush, stall_ex, branch_cnt, mispred_cnt
  );

  modport slave (
    input  ex_valid, ex_pc, ex_opcode, ex_funct3, ex_rs1_val, ex_rs2_val,
           ex_imm, ex_pred_pc, redirect_ready,
    output redirect_valid, redirect_pc, flush, stall_ex, branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/branch_resolve_cmp.sv
// branch_cmp: evaluates the conditional-branch predicate selected by funct3.
// Ports: funct3 (condition select), rs1/rs2 (operands), taken (result).
// Reserved funct3 codes (010/011) report not-taken.
module branch_cmp
  import branch_resolve_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [2:0]   funct3,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic         taken
);

  // Pure combinational condition decode.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: computes the real next PC of the EX-stage instruction,
// compares it with the fetch-side prediction and, on a mismatch, issues a
// redirect to the IFU while flushing the front of the pipe.
// Ports: clk, rst (async, active-high), bus (branch_resolve_if.slave):
//   ex_* instruction inputs, redirect_valid/redirect_pc/redirect_ready
//   handshake, flush, stall_ex, branch_cnt and mispred_cnt counters.
module branch_resolve
  import branch_resolve_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);

  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] actual_pc;
  logic            taken;
  logic            is_cti;
  logic            accept;
  logic            mispredict;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] redirect_pc_q;
  logic [31:0]     branch_cnt_q;
  logic [31:0]     mispred_cnt_q;
  logic            redirect_valid_c;
  logic            flush_c;
  logic            stall_c;

  branch_cmp #(.W(XLEN)) u_cmp (
    .funct3 (bus.ex_funct3),
    .rs1    (bus.ex_rs1_val),
    .rs2    (bus.ex_rs2_val),
    .taken  (taken)
  );

  assign imm_x       = XLEN'($signed(bus.ex_imm));
  assign pc_plus4    = bus.ex_pc + XLEN'(4);
  assign pc_plus_imm = bus.ex_pc + imm_x;
  assign jalr_sum    = bus.ex_rs1_val + imm_x;

  // Actual next-PC selection; anything that is not a control transfer
  // simply falls through to pc+4.
  always_comb begin
    actual_pc = pc_plus4;
    is_cti    = 1'b0;
    case (bus.ex_opcode)
      OPCODE_JAL: begin
        actual_pc = pc_plus_imm;
        is_cti    = 1'b1;
      end
      OPCODE_JALR: begin
        actual_pc = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
        is_cti    = 1'b1;
      end
      OPCODE_BREACH: begin
        actual_pc = taken ? pc_plus_imm : pc_plus4;
        is_cti    = 1'b1;
      end
      default: ;
    endcase
  end

  // EX instructions are only looked at while idle; during a redirect the
  // EX stage holds junk that is about to be flushed.
  assign accept     = (state_q == ST_IDLE) && bus.ex_valid;
  assign mispredict = accept && (actual_pc != bus.ex_pred_pc);

  // State register, captured redirect target and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (mispredict) begin
        redirect_pc_q <= actual_pc;
        mispred_cnt_q <= sat_inc(mispred_cnt_q);
      end
      if (accept && is_cti) begin
        branch_cnt_q <= sat_inc(branch_cnt_q);
      end
    end
  end

  // Next-state and Moore outputs. REDIRECT may last a single cycle when the
  // IFU is already ready as redirect_valid rises.
  always_comb begin
    state_d          = state_q;
    redirect_valid_c = 1'b0;
    flush_c          = 1'b0;
    stall_c          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid_c = 1'b1;
        flush_c          = 1'b1;
        stall_c          = 1'b1;
        if (bus.redirect_ready) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_c = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_c;
  assign bus.stall_ex       = stall_c;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: a table of single-instruction
// vectors with hand-derived expected redirects, plus hand-written
// sequences for held redirects, back-to-back mispredicts with a saturated
// counter, and reset during a redirect.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_resolve_if bus();

  branch_resolve dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pred;
    logic        cti;
    logic        exp_redirect;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic        redirect;
    logic [31:0] pc;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  localparam logic [6:0] OP_ALU = 7'h33;
  localparam int NVEC = 13;

  int          tests  = 0;
  int          failed = 0;
  logic [31:0] br_exp = 0;
  logic [31:0] mp_exp = 0;
  exp_t        sb[$];
  vec_t        vecs[NVEC];

  function automatic logic [31:0] satModel(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) return v;
    return v + 32'd1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveEx(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pred);
    bus.ex_valid   = 1'b1;
    bus.ex_opcode  = op;
    bus.ex_funct3  = f3;
    bus.ex_pc      = pc;
    bus.ex_rs1_val = rs1;
    bus.ex_rs2_val = rs2;
    bus.ex_imm     = imm;
    bus.ex_pred_pc = pred;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    driveEx(v.opcode, v.funct3, v.pc, v.rs1, v.rs2, v.imm, v.pred);
    if (v.cti) br_exp = satModel(br_exp);
    if (v.exp_redirect) mp_exp = satModel(mp_exp);
    e.redirect = v.exp_redirect;
    e.pc       = v.exp_pc;
    e.br       = br_exp;
    e.mp       = mp_exp;
    sb.push_back(e);
    step();
    bus.ex_valid = 1'b0;
  endtask

  task automatic checkResult(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, ".scoreboard_entry"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(e.redirect));
    checkOutput({tag, ".stall_ex"}, 32'(bus.stall_ex), 32'(e.redirect));
    if (e.redirect) checkOutput({tag, ".redirect_pc"}, bus.redirect_pc, e.pc);
    checkOutput({tag, ".branch_cnt"}, bus.branch_cnt, e.br);
    checkOutput({tag, ".mispred_cnt"}, bus.mispred_cnt, e.mp);
  endtask

  task automatic finishRedirect(input string tag);
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
    checkOutput({tag, ".flushcyc_valid"}, 32'(bus.redirect_valid), 32'd0);
    checkOutput({tag, ".flushcyc_flush"}, 32'(bus.flush), 32'd1);
    checkOutput({tag, ".flushcyc_stall"}, 32'(bus.stall_ex), 32'd0);
    step();
    checkOutput({tag, ".idle_flush"}, 32'(bus.flush), 32'd0);
    checkOutput({tag, ".idle_valid"}, 32'(bus.redirect_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OPCODE_BREACH, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 32'h104, 1'b1, 1'b1, 32'h120};
    vecs[1]  = '{OPCODE_JAL, 3'b000, 32'h200, 32'd0, 32'd0, 32'h40, 32'h240, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{OPCODE_BREACH, 3'b110, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h310, 1'b1, 1'b1, 32'h304};
    vecs[3]  = '{OPCODE_BREACH, 3'b100, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h304, 1'b1, 1'b1, 32'h310};
    vecs[4]  = '{OPCODE_BREACH, 3'b001, 32'h400, 32'd3, 32'd4, 32'hFFFF_FFF0, 32'h3F0, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{OPCODE_BREACH, 3'b101, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h508, 1'b1, 1'b1, 32'h504};
    vecs[6]  = '{OPCODE_BREACH, 3'b111, 32'h600, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h608, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{OPCODE_BREACH, 3'b010, 32'h700, 32'd0, 32'd0, 32'h8, 32'h708, 1'b1, 1'b1, 32'h704};
    vecs[8]  = '{OP_ALU, 3'b000, 32'h800, 32'd0, 32'd0, 32'h0, 32'h804, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{OP_ALU, 3'b000, 32'h800, 32'd0, 32'd0, 32'h0, 32'h900, 1'b0, 1'b1, 32'h804};
    vecs[10] = '{OPCODE_JAL, 3'b000, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20, 32'h10, 1'b1, 1'b0, 32'h0};
    vecs[11] = '{OPCODE_JALR, 3'b000, 32'h20, 32'h1001, 32'd0, 32'hFFFF_FFFF, 32'h1000, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{OPCODE_BREACH, 3'b110, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h304, 1'b1, 1'b0, 32'h0};

    rst = 1'b1;
    bus.redirect_ready = 1'b0;
    driveEx(7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.ex_valid = 1'b0;
    step();
    step();
    checkOutput("reset.redirect_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("reset.redirect_pc", bus.redirect_pc, 32'd0);
    checkOutput("reset.flush", 32'(bus.flush), 32'd0);
    checkOutput("reset.stall_ex", 32'(bus.stall_ex), 32'd0);
    checkOutput("reset.branch_cnt", bus.branch_cnt, 32'd0);
    checkOutput("reset.mispred_cnt", bus.mispred_cnt, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkResult($sformatf("vec%0d", i));
      if (vecs[i].exp_redirect) finishRedirect($sformatf("vec%0d", i));
    end

    // JALR with a slow IFU; EX keeps presenting a would-be mispredict that
    // must be ignored through REDIRECT and FLUSH.
    applyStimulus('{OPCODE_JALR, 3'b000, 32'h80, 32'h301, 32'd0, 32'h4, 32'h308, 1'b1, 1'b1, 32'h304});
    driveEx(OPCODE_BREACH, 3'b000, 32'h900, 32'd7, 32'd7, 32'h40, 32'h904);
    checkResult("jalr");
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("jalr.hold%0d.valid", k), 32'(bus.redirect_valid), 32'd1);
      checkOutput($sformatf("jalr.hold%0d.stall", k), 32'(bus.stall_ex), 32'd1);
      checkOutput($sformatf("jalr.hold%0d.flush", k), 32'(bus.flush), 32'd1);
      checkOutput($sformatf("jalr.hold%0d.pc", k), bus.redirect_pc, 32'h304);
    end
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
    checkOutput("jalr.flushcyc_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("jalr.flushcyc_flush", 32'(bus.flush), 32'd1);
    checkOutput("jalr.flushcyc_stall", 32'(bus.stall_ex), 32'd0);
    step();
    bus.ex_valid = 1'b0;
    checkOutput("jalr.idle_flush", 32'(bus.flush), 32'd0);
    checkOutput("jalr.idle_valid", 32'(bus.redirect_valid), 32'd0);
    step();
    checkOutput("jalr.ignored_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("jalr.ignored_branch_cnt", bus.branch_cnt, br_exp);
    checkOutput("jalr.ignored_mispred_cnt", bus.mispred_cnt, mp_exp);

    // Back-to-back mispredicts with the mispredict counter preloaded to
    // all-ones while in the FLUSH cycle.
    applyStimulus('{OPCODE_BREACH, 3'b000, 32'hA00, 32'd1, 32'd1, 32'h10, 32'hA04, 1'b1, 1'b1, 32'hA10});
    checkResult("b2b.first");
    bus.redirect_ready = 1'b1;
    step();
    bus.redirect_ready = 1'b0;
    checkOutput("b2b.flushcyc_flush", 32'(bus.flush), 32'd1);
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt_q;
    mp_exp = 32'hFFFF_FFFF;
    step();
    applyStimulus('{OPCODE_JAL, 3'b000, 32'hB00, 32'd0, 32'd0, 32'h100, 32'hB04, 1'b1, 1'b1, 32'hC00});
    checkResult("b2b.second");
    finishRedirect("b2b.second");
    checkOutput("b2b.sat_mispred_cnt", bus.mispred_cnt, 32'hFFFF_FFFF);

    // Reset in the middle of a redirect while the IFU is ready.
    applyStimulus('{OPCODE_BREACH, 3'b001, 32'hD00, 32'd1, 32'd2, 32'h40, 32'hD04, 1'b1, 1'b1, 32'hD40});
    checkResult("rstmid.redirect");
    bus.redirect_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    br_exp = 0;
    mp_exp = 0;
    checkOutput("rstmid.redirect_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("rstmid.redirect_pc", bus.redirect_pc, 32'd0);
    checkOutput("rstmid.flush", 32'(bus.flush), 32'd0);
    checkOutput("rstmid.stall_ex", 32'(bus.stall_ex), 32'd0);
    checkOutput("rstmid.branch_cnt", bus.branch_cnt, 32'd0);
    checkOutput("rstmid.mispred_cnt", bus.mispred_cnt, 32'd0);
    step();
    rst = 1'b0;
    step();
    checkOutput("rstmid.after_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("rstmid.after_flush", 32'(bus.flush), 32'd0);
    bus.redirect_ready = 1'b0;
    step();
    checkOutput("rstmid.after2_valid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("rstmid.after2_mispred_cnt", bus.mispred_cnt, 32'd0);

    applyStimulus(vecs[0]);
    checkResult("resume");
    finishRedirect("resume");

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
